// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: write-side character FIFO feeding an 8N1-style UART transmitter.
// Latency: a write into an empty FIFO with the line idle starts the start bit on the next edge.
// Flow: a write while full is dropped and sets a sticky overflow flag; the write path never stalls.
// Optional build macro UART_TX_SIM_ECHO_EN echoes each accepted character to the sim console.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   ovf_clr,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q;
  logic                 push, pop;

  // Transmitter state
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 baud_end;

  // full is taken from the registered count, so a same-cycle pop never rescues a write
  assign push     = wr_en && !full;
  assign baud_end = (baud_q == BAUD_LAST);

  // Occupancy next-state: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Sticky overflow: a dropped write wins over a clear in the same cycle
  always_ff @(posedge clock) begin
    if (reset)             ovf_q <= 1'b0;
    else if (wr_en && full) ovf_q <= 1'b1;
    else if (ovf_clr)       ovf_q <= 1'b0;
  end

`ifdef UART_TX_SIM_ECHO_EN
  // Console echo of accepted characters; does not touch the serial path
  always_ff @(posedge clock) begin
    if (!reset && push) $write("%c", wr_data);
  end
`endif

  // Transmitter state register; tx is registered here so the line never glitches
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: sequence START/DATA/STOP, popping the next character without an idle gap
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Outputs: status flags decoded from registered state only
  always_comb begin
    tx       = tx_q;
    busy     = (state_q != IDLE);
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default instance checked through a serial-line
// scoreboard, plus a 7-bit / 2-stop / 3-clock instance checked frame by frame.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst, wr_en, ovf_clr;
  logic [7:0] wr_data;
  logic       tx0, busy0, full0, empty0, ovf0;
  logic [4:0] count0;

  uart_tx_fifo dut0 (
    .clock(clk), .reset(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx0), .busy(busy0), .full(full0), .empty(empty0), .count(count0), .overflow(ovf0)
  );

  // 7 data bits, 2 stop bits, 3 clocks per bit
  logic       wr1_en;
  logic [6:0] wr1_dat;
  logic       tx1, busy1, full1, empty1, ovf1;
  logic [4:0] count1;

  uart_tx_fifo #(.CLKS_PER_BIT(3), .DEPTH(16), .DATA_BITS(7), .STOP_BITS(2)) dut1 (
    .clock(clk), .reset(rst), .wr_en(wr1_en), .wr_data(wr1_dat), .ovf_clr(1'b0),
    .tx(tx1), .busy(busy1), .full(full1), .empty(empty1), .count(count1), .overflow(ovf1)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted characters in order; the line monitor pops one per frame
  logic [7:0] exp_q[$];
  bit         mon_act    = 1'b0;
  int         mon_cnt    = 0;
  logic [9:0] mon_frame  = '0;
  int         frames_done = 0;
  int         last_start = 0;
  int         prev_start = 0;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      mon_act = 1'b0;
      exp_q.delete();
    end else if (!mon_act) begin
      if (tx0 === 1'b0) begin
        chk("sb_frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_frame  = {1'b1, exp_q.pop_front(), 1'b0};
          prev_start = last_start;
          last_start = cyc;
          mon_act    = 1'b1;
          mon_cnt    = 1;
          chk("busy_at_start", busy0, 1);
        end
      end
    end else begin
      chk("line_bit", tx0, mon_frame[mon_cnt/4]);
      chk("busy_in_frame", busy0, 1);
      mon_cnt++;
      if (mon_cnt == 40) begin
        mon_act = 1'b0;
        frames_done++;
      end
    end
  end

  task automatic wr0(input logic [7:0] d, input bit accepted);
    wr_en   = 1'b1;
    wr_data = d;
    if (accepted) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic frame1(input logic [6:0] d);
    logic [9:0] f;
    f       = {2'b11, d, 1'b0};
    wr1_en  = 1'b1;
    wr1_dat = d;
    @(negedge clk);
    wr1_en = 1'b0;
    chk("f1_tx_before_start", tx1, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("f1_line_bit", tx1, f[i/3]);
      chk("f1_busy", busy1, 1);
    end
    @(negedge clk);
    chk("f1_busy_after", busy1, 0);
    chk("f1_tx_after", tx1, 1);
    chk("f1_empty_after", empty1, 1);
  endtask

  initial begin
    int wcyc, fd, maxc, lows;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    wr1_en = 1'b0; wr1_dat = '0;
    idle(2);
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_count", count0, 0);
    chk("rst_ovf", ovf0, 0);
    rst = 1'b0;
    idle(2);

    // Single 0x41 frame, latency and return to idle
    fd = frames_done;
    wr0(8'h41, 1'b1);
    wr_en = 1'b0;
    wcyc = cyc;
    chk("a_count_after_write", count0, 1);
    chk("a_tx_still_high", tx0, 1);
    idle(45);
    chk("a_latency", last_start, wcyc + 1);
    chk("a_frames", frames_done, fd + 1);
    chk("a_empty", empty0, 1);
    chk("a_busy_low", busy0, 0);
    chk("a_tx_idle", tx0, 1);

    // Back-to-back frames with no idle gap
    fd = frames_done;
    wr0(8'h55, 1'b1);
    wr0(8'hAA, 1'b1);
    wr_en = 1'b0;
    maxc = count0;
    for (int i = 0; i < 90; i++) begin
      if (count0 > maxc) maxc = count0;
      @(negedge clk);
    end
    chk("b_count_peak", maxc, 1);
    chk("b_frames", frames_done, fd + 2);
    chk("b_gap", last_start - prev_start, 40);
    chk("b_empty", empty0, 1);

    // Overfill: 17 accepted, 18th dropped
    fd = frames_done;
    for (int i = 0; i < 17; i++) begin
      wr0(8'(i), 1'b1);
      if (i == 0) wcyc = cyc;
    end
    chk("c_full_after_17", full0, 1);
    chk("c_count_16", count0, 16);
    chk("c_ovf_not_yet", ovf0, 0);
    wr0(8'h11, 1'b0);
    wr_en = 1'b0;
    chk("c_ovf_set", ovf0, 1);
    chk("c_count_unchanged", count0, 16);
    idle(720);
    chk("c_first_pop_latency", frames_done > fd, 1);
    chk("c_frames", frames_done, fd + 17);
    chk("c_sb_drained", exp_q.size(), 0);
    chk("c_empty", empty0, 1);

    // Overflow clear, then clear racing a dropped write
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("d_ovf_cleared", ovf0, 0);
    for (int i = 0; i < 17; i++) wr0(8'h80 + 8'(i), 1'b1);
    wr0(8'hEE, 1'b0);
    chk("d_ovf_set_again", ovf0, 1);
    wr_data = 8'h99;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("d_set_beats_clear", ovf0, 1);
    chk("d_count_16", count0, 16);
    idle(720);
    chk("d_sb_drained", exp_q.size(), 0);
    chk("d_empty", empty0, 1);

    // Reset 12 cycles into a frame with 3 bytes queued
    fd = frames_done;
    wr0(8'hC3, 1'b1);
    wr0(8'h3C, 1'b1);
    wr0(8'h5A, 1'b1);
    wr0(8'hA5, 1'b1);
    wr_en = 1'b0;
    chk("e_count_3", count0, 3);
    idle(9);
    chk("e_mid_frame_busy", busy0, 1);
    rst = 1'b1;
    wr_en = 1'b1; wr_data = 8'h77; ovf_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0;
    chk("e_tx", tx0, 1);
    chk("e_busy", busy0, 0);
    chk("e_count", count0, 0);
    chk("e_empty", empty0, 1);
    chk("e_full", full0, 0);
    chk("e_ovf", ovf0, 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
    end
    chk("e_line_quiet", lows, 0);
    chk("e_no_frames", frames_done, fd);

    // Narrow frame format on the second instance
    frame1(7'h7F);
    frame1(7'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
